// File: rtl/tdm_demux16_pkg.sv
// Shared definitions for the 16:1 TDM demultiplexer path.
// Optional macro: TDM_DEMUX_PARITY_EN adds one even-parity slot per frame.
package tdm_pkg;

   localparam int N_CH_DEF = 16;

`ifdef TDM_DEMUX_PARITY_EN
   localparam int SEL_W_DEF   = 5;
   localparam int N_SLOTS_DEF = N_CH_DEF + 1;
`else
   localparam int SEL_W_DEF   = 4;
   localparam int N_SLOTS_DEF = N_CH_DEF;
`endif

   // Index of the final slot of a frame (data or parity slot).
   localparam int LAST_SLOT_DEF = N_SLOTS_DEF - 1;

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   // Per-beat decision shared by the FSM and the slot counter.
   typedef enum logic [2:0] {
      ACT_NONE  = 3'd0,
      ACT_START = 3'd1,
      ACT_LOSE  = 3'd2,
      ACT_STORE = 3'd3,
      ACT_LAST  = 3'd4
   } act_t;

endpackage

// File: rtl/tdm_demux16_slot_ctr.sv
// Slot counter shared by the TDM transmitter scanner and receiver demux.
// Controls in priority order: clear to 0, load to 1, increment (wrapping
// after the last slot); otherwise hold.
module tdm_slot_ctr #(
   parameter int SEL_W = 4,
   parameter int LAST  = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_load1,
   input  logic             i_inc,
   output logic [SEL_W-1:0] o_sel,
   output logic             o_is_last
);

   localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};
   localparam logic [SEL_W-1:0] SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(LAST);

   logic [SEL_W-1:0] r_sel;

   // Slot index register with clear/load/increment/hold controls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel <= SEL_ZERO;
      end else if (i_clear) begin
         r_sel <= SEL_ZERO;
      end else if (i_load1) begin
         r_sel <= SEL_ONE;
      end else if (i_inc) begin
         if (r_sel == SEL_LAST) begin
            r_sel <= SEL_ZERO;
         end else begin
            r_sel <= r_sel + SEL_ONE;
         end
      end else begin
         r_sel <= r_sel;
      end
   end

   assign o_sel     = r_sel;
   assign o_is_last = (r_sel == SEL_LAST);

endmodule

// File: rtl/tdm_demux16.sv
// Receive-side 16:1 TDM demultiplexer: serial beats are steered into a
// shadow frame by slot index and committed atomically to dout.
// Optional macro: TDM_DEMUX_PARITY_EN (extra even-parity slot N_CH).
module tdm_demux16
   import tdm_pkg::*;
#(
   parameter int N_CH  = N_CH_DEF,
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [SEL_W-1:0] sel,
   output logic [N_CH-1:0]  dout,
   output logic             frame_valid,
   output logic             locked,
   output logic             sync_err,
   output logic             parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
   // Every data slot is buffered; the parity beat completes the frame.
   localparam int LAST_SLOT = N_CH;
   localparam int SHADOW_W  = N_CH;
`else
   // The last data bit goes straight from din into dout on commit.
   localparam int LAST_SLOT = N_CH - 1;
   localparam int SHADOW_W  = N_CH - 1;
`endif
   localparam int IDX_W = $clog2(SHADOW_W);

   localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};

   state_t              r_state;
   logic [SHADOW_W-1:0] r_shadow;
   logic [N_CH-1:0]     r_dout;
   logic                r_frame_valid;
   logic                r_locked;
   logic                r_sync_err;

   act_t                w_act;
   logic                w_early;
   logic [SEL_W-1:0]    w_sel;
   logic                w_is_last;
   logic [IDX_W-1:0]    w_idx;

`ifdef TDM_DEMUX_PARITY_EN
   logic                r_parity_err;

   // Even parity: data bits XOR parity bit must be zero.
   function automatic logic parity_ok(input logic [SHADOW_W-1:0] data,
                                      input logic              par);
      return ((^data) ^ par) == 1'b0;
   endfunction
`endif

   assign w_idx = w_sel[IDX_W-1:0];

   // Classify the current beat from state, slot position and sync.
   always_comb begin
      w_act   = ACT_NONE;
      w_early = 1'b0;
      if (!din_valid) begin
         w_act = ACT_NONE;
      end else if (r_state == ST_HUNT) begin
         if (sync) begin
            w_act = ACT_START;
         end else begin
            w_act = ACT_NONE;
         end
      end else if (sync) begin
         w_act   = ACT_START;
         w_early = (w_sel != SEL_ZERO);
      end else if (w_sel == SEL_ZERO) begin
         w_act = ACT_LOSE;
      end else if (w_is_last) begin
         w_act = ACT_LAST;
      end else begin
         w_act = ACT_STORE;
      end
   end

   tdm_slot_ctr #(
      .SEL_W (SEL_W),
      .LAST  (LAST_SLOT)
   ) u_slot_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   ((w_act == ACT_LOSE) || (w_act == ACT_LAST)),
      .i_load1   (w_act == ACT_START),
      .i_inc     (w_act == ACT_STORE),
      .o_sel     (w_sel),
      .o_is_last (w_is_last)
   );

   // Alignment FSM, shadow capture, frame commit and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_HUNT;
         r_shadow      <= {SHADOW_W{1'b0}};
         r_dout        <= {N_CH{1'b0}};
         r_frame_valid <= 1'b0;
         r_locked      <= 1'b0;
         r_sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         r_parity_err  <= 1'b0;
`endif
      end else begin
         r_frame_valid <= 1'b0;
         r_sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         r_parity_err  <= 1'b0;
`endif
         case (w_act)
            ACT_START: begin
               // Also covers early sync: any partial frame is dropped.
               r_shadow   <= {{(SHADOW_W-1){1'b0}}, din};
               r_state    <= ST_RECV;
               r_locked   <= 1'b1;
               r_sync_err <= w_early;
            end
            ACT_LOSE: begin
               r_shadow   <= {SHADOW_W{1'b0}};
               r_state    <= ST_HUNT;
               r_locked   <= 1'b0;
               r_sync_err <= 1'b1;
            end
            ACT_STORE: begin
               r_shadow[w_idx] <= din;
            end
            ACT_LAST: begin
`ifdef TDM_DEMUX_PARITY_EN
               if (parity_ok(r_shadow, din)) begin
                  r_dout        <= r_shadow;
                  r_frame_valid <= 1'b1;
               end else begin
                  r_parity_err  <= 1'b1;
               end
`else
               r_dout        <= {din, r_shadow};
               r_frame_valid <= 1'b1;
`endif
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   assign sel         = w_sel;
   assign dout        = r_dout;
   assign frame_valid = r_frame_valid;
   assign locked      = r_locked;
   assign sync_err    = r_sync_err;
`ifdef TDM_DEMUX_PARITY_EN
   assign parity_err  = r_parity_err;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux16.sv
// Scoreboard bench for tdm_demux16: expected frames are queued when a frame
// is sent; a negedge monitor pops and compares on every frame_valid pulse.
module tb_tdm_demux16;
   import tdm_pkg::*;

   localparam int N  = 16;
   localparam int SW = SEL_W_DEF;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b1;
   logic          din       = 1'b0;
   logic          din_valid = 1'b0;
   logic          sync      = 1'b0;
   logic [SW-1:0] sel;
   logic [N-1:0]  dout;
   logic          frame_valid;
   logic          locked;
   logic          sync_err;
   logic          parity_err;

   int n_tests  = 0;
   int n_fail   = 0;
   int n_frames = 0;
   int n_serr   = 0;
   int n_perr   = 0;
   logic [N-1:0] exp_q[$];

   always #5 clk = ~clk;

   tdm_demux16 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .sync        (sync),
      .sel         (sel),
      .dout        (dout),
      .frame_valid (frame_valid),
      .locked      (locked),
      .sync_err    (sync_err),
      .parity_err  (parity_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare on every committed frame, count error pulses.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (frame_valid === 1'b1) begin
            n_frames++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_frame: got dout 0x%0h, expected no frame", dout);
            end else begin
               check("frame_dout", {16'h0, dout}, {16'h0, exp_q.pop_front()});
            end
         end
         if (sync_err === 1'b1)   n_serr++;
         if (parity_err === 1'b1) n_perr++;
      end
   end

   task automatic beat(input logic b, input logic s);
      din       = b;
      sync      = s;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      sync      = 1'b0;
      din       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One frame, slot k = bit k; optional idle gaps; parity slot when enabled.
   task automatic frame(input logic [N-1:0] d, input bit gaps, input bit bad_par);
      for (int k = 0; k < N; k++) begin
         beat(d[k], (k == 0));
         if (gaps && (k % 3 == 1)) idle($urandom_range(1, 3));
      end
`ifdef TDM_DEMUX_PARITY_EN
      beat((^d) ^ bad_par, 1'b0);
`else
      if (bad_par) idle(0);
`endif
   endtask

   initial begin
      // Reset values while rst_n is held low.
      #1 rst_n = 1'b0;
      #1;
      check("rst_dout",       {16'h0, dout}, 32'h0);
      check("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
      check("rst_locked",     {31'h0, locked}, 32'h0);
      check("rst_sel",        32'(sel), 32'h0);
      check("rst_sync_err",   {31'h0, sync_err}, 32'h0);
      check("rst_parity_err", {31'h0, parity_err}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Single frame 0xA5C3.
      exp_q.push_back(16'hA5C3);
      frame(16'hA5C3, 1'b0, 1'b0);
      idle(2);
      check("f1_frames", 32'(n_frames), 32'd1);
      check("f1_dout",   {16'h0, dout}, 32'h0000A5C3);
      check("f1_locked", {31'h0, locked}, 32'h1);
      check("f1_sel",    32'(sel), 32'h0);
      check("f1_serr",   32'(n_serr), 32'd0);

      // Two frames with idle gaps, then two at full rate back-to-back.
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'hFFFF);
      frame(16'h1234, 1'b1, 1'b0);
      frame(16'hFFFF, 1'b1, 1'b0);
      idle(2);
      check("gap_frames", 32'(n_frames), 32'd3);
      check("gap_dout",   {16'h0, dout}, 32'h0000FFFF);
      check("gap_serr",   32'(n_serr), 32'd0);
      exp_q.push_back(16'h8001);
      exp_q.push_back(16'h7FFE);
      frame(16'h8001, 1'b0, 1'b0);
      frame(16'h7FFE, 1'b0, 1'b0);
      idle(2);
      check("b2b_frames", 32'(n_frames), 32'd5);
      check("b2b_dout",   {16'h0, dout}, 32'h00007FFE);
      check("b2b_serr",   32'(n_serr), 32'd0);

      // Early sync at slot 7: partial frame dropped, new frame committed.
      beat(1'b1, 1'b1);
      for (int k = 1; k < 7; k++) beat(1'b1, 1'b0);
      check("early_sel", 32'(sel), 32'd7);
      exp_q.push_back(16'h00F0);
      frame(16'h00F0, 1'b0, 1'b0);
      idle(2);
      check("early_serr",   32'(n_serr), 32'd1);
      check("early_frames", 32'(n_frames), 32'd6);
      check("early_dout",   {16'h0, dout}, 32'h000000F0);

      // Missing sync at slot 0: lose lock, ignore beats until sync.
      beat(1'b1, 1'b0);
      idle(2);
      check("miss_serr",   32'(n_serr), 32'd2);
      check("miss_locked", {31'h0, locked}, 32'h0);
      repeat (5) beat(1'b1, 1'b0);
      check("hunt_sel",    32'(sel), 32'h0);
      check("hunt_locked", {31'h0, locked}, 32'h0);
      check("hunt_serr",   32'(n_serr), 32'd2);
      check("hunt_dout",   {16'h0, dout}, 32'h000000F0);
      exp_q.push_back(16'h5A5A);
      frame(16'h5A5A, 1'b0, 1'b0);
      idle(2);
      check("relock_locked", {31'h0, locked}, 32'h1);
      check("relock_dout",   {16'h0, dout}, 32'h00005A5A);

      // Asynchronous reset mid-frame at slot 9.
      beat(1'b1, 1'b1);
      for (int k = 1; k < 9; k++) beat(1'b1, 1'b0);
      check("mid_sel", 32'(sel), 32'd9);
      #2 rst_n = 1'b0;
      #1;
      check("arst_dout",   {16'h0, dout}, 32'h0);
      check("arst_locked", {31'h0, locked}, 32'h0);
      check("arst_sel",    32'(sel), 32'h0);
      check("arst_fv",     {31'h0, frame_valid}, 32'h0);
      #3 rst_n = 1'b1;
      idle(2);
      repeat (3) beat(1'b1, 1'b0);
      check("post_rst_locked", {31'h0, locked}, 32'h0);
      check("post_rst_sel",    32'(sel), 32'h0);
      exp_q.push_back(16'h0F0F);
      frame(16'h0F0F, 1'b0, 1'b0);
      idle(2);
      check("post_rst_dout",   {16'h0, dout}, 32'h00000F0F);
      check("post_rst_frames", 32'(n_frames), 32'd8);

`ifdef TDM_DEMUX_PARITY_EN
      // Good parity commits; bad parity pulses parity_err and holds dout.
      exp_q.push_back(16'h0003);
      frame(16'h0003, 1'b0, 1'b0);
      idle(2);
      check("par_ok_dout", {16'h0, dout}, 32'h00000003);
      check("par_ok_perr", 32'(n_perr), 32'd0);
      frame(16'h0001, 1'b0, 1'b1);
      idle(2);
      check("par_bad_perr",   32'(n_perr), 32'd1);
      check("par_bad_dout",   {16'h0, dout}, 32'h00000003);
      check("par_bad_frames", 32'(n_frames), 32'd9);
      check("par_bad_locked", {31'h0, locked}, 32'h1);
      check("par_bad_sel",    32'(sel), 32'h0);
`else
      check("no_par_perr", 32'(n_perr), 32'd0);
`endif

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- Receive side of the 16:1 channel-scanning mux path: takes one serial bit per valid beat and routes it into the 16-bit output slot selected by an internal slot counter. This is the demultiplexer counterpart to the transmitter's select sequencing.
- Frame alignment comes from a sync strobe marking slot 0.
- Completed frames are committed atomically to a parallel output register with a one-cycle frame strobe.
- Sits between the serial link and downstream parallel consumers.

Parameters:
- N_CH, 16, number of channels/slots per frame.
- SEL_W, 4, slot counter width; must satisfy 2**SEL_W >= N_CH (+1 when parity enabled).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  beat qualifier; all state advances only on beats with din_valid=1.
- sync  input  1  frame start marker; meaningful only when din_valid=1.
- sel  output  SEL_W  current slot index, the next beat's destination.
- dout  output  N_CH  last committed frame; bit k = slot k.
- frame_valid  output  1  one-cycle pulse, same cycle dout updates.
- locked  output  1  high while in RECV.
- sync_err  output  1  one-cycle pulse on alignment violation.
- parity_err  output  1  one-cycle pulse on parity failure; constant 0 when the feature is compiled out.

Behaviour:
- Reset (async assert, sync-free deassert): state=HUNT, sel=0, shadow=0, dout=0, frame_valid=0, locked=0, sync_err=0, parity_err=0.
- States: HUNT, RECV. locked = (state==RECV), registered.
- HUNT behaviour:
  - Beats without sync are discarded.
  - A beat with sync stores din into shadow[0], sets sel=1, and moves to RECV.
- RECV, valid beat, no sync, sel in 1..N_CH-2: shadow[sel]<=din, sel<=sel+1.
- RECV, valid beat, no sync, sel==N_CH-1 (last data slot, no parity):
  - Next cycle: dout <= {din, shadow[N_CH-2:0]} and frame_valid=1.
  - sel wraps to 0; state stays RECV.
- RECV, valid beat at sel==0:
  - With sync: normal frame start, same as the HUNT entry (shadow[0]<=din, sel<=1).
  - Without sync: sync_err pulse, shadow discarded, go to HUNT, sel<=0.
- RECV, valid beat with sync at sel!=0 (early sync):
  - sync_err pulse; partial frame discarded (no commit).
  - The beat is taken as slot 0: shadow[0]<=din, sel<=1, stay RECV.
- din_valid=0: all state holds; pulses deassert.
- Latency: the last slot beat at edge n gives dout/frame_valid visible after edge n; outputs are registered.
- Back-to-back frames are allowed at full rate (sync on the beat right after the last slot).
- dout holds its value between commits; it never shows a partial frame.
- Reset mid-frame: the partial frame is lost; dout is cleared to 0.

Optional Feature:
- Macro TDM_DEMUX_PARITY_EN.
- Defined:
  - The frame has N_CH+1 slots; slot N_CH carries even parity over the data bits.
  - On the parity beat, XOR(shadow data, din)==0 gives a commit plus frame_valid.
  - Otherwise parity_err pulses, dout is held, and there is no frame_valid. State stays RECV and sel wraps to 0.
  - Sync/alignment rules apply with last slot = N_CH.
- Undefined: the frame is N_CH slots and parity_err is tied 0.

Decomposition:
- Shared package/header (tdm_pkg): state encodings (HUNT=1'b0, RECV=1'b1), default N_CH/SEL_W, last-slot constant computed from the parity macro.
- One sub-module: tdm_slot_ctr.
  - Counter with load-to-1, wrap, and hold controls.
  - Exposes sel and is_last.
  - Reusable by the transmitter-side scanner.

Test Plan:
- Reset, then sync+16 beats carrying 0xA5C3 (slot k = bit k) → dout=0xA5C3, frame_valid single pulse, locked=1, sel=0 afterwards.
- Two back-to-back frames 0x1234 then 0xFFFF with random din_valid gaps → two frame_valid pulses; dout=0x1234 then 0xFFFF; no sync_err.
- Early sync at slot 7 of a frame, then 16 beats of 0x00F0 → one sync_err; no commit of the partial frame; then dout=0x00F0.
- Missing sync after a complete frame (beat at sel=0 without sync) → sync_err, locked=0; beats without sync are ignored until sync; dout unchanged.
- Assert rst_n=0 asynchronously mid-frame at slot 9 → all outputs 0 immediately; after release, state is HUNT.
- With TDM_DEMUX_PARITY_EN: frame 0x0003 with parity 0 → commit; frame 0x0001 with parity 0 → parity_err, dout stays 0x0003.
